// File: rtl/delay_line_prog.sv
// delay_line_prog: runtime-programmable, multi-lane synchronous delay line.
//
// A DEPTH-stage shift register of WIDTH-bit words. Each enabled clock edge
// pushes f(din) into stage 0. The output is a combinational tap on the stage
// selected by the latched delay. Latency is delay_q+1 enabled edges.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset; takes priority over en and cfg_load
//   en         advance enable; 0 freezes the chain and the fill counter
//   cfg_load   1-cycle strobe that latches cfg_delay/cfg_mode and restarts fill tracking
//   cfg_delay  tap select; delay = cfg_delay+1 enabled edges, clamped to DEPTH-1
//   cfg_mode   input function: 00 pass, 01 AND-reduce, 10 XOR-reduce, 11 invert
//   din        input sample
//   dout       tapped output (stage[delay_q])
//   dout_valid high once the tapped stage holds data sampled since the last reset/cfg_load
module delay_line_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 128,
    parameter bit          RESET_VAL = 1'b1,
    localparam int unsigned DW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_delay,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    localparam int unsigned CW = DW + 1;
    localparam logic [DW-1:0] MaxDelay = DW'(DEPTH - 1);
    localparam logic [CW-1:0] FillMax  = CW'(DEPTH);
    localparam logic [1:0] ModePass = 2'b00;
    localparam logic [1:0] ModeAnd  = 2'b01;
    localparam logic [1:0] ModeXor  = 2'b10;
    localparam logic [1:0] ModeInv  = 2'b11;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DW-1:0]    delay_q, delay_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0] din_f;

    // Input function uses the mode latched before this edge, so a cfg_load
    // coinciding with en still shifts with the old mode.
    always_comb begin
        din_f = din;
        unique case (mode_q)
            ModePass: din_f = din;
            ModeAnd:  din_f = {WIDTH{&din}};
            ModeXor:  din_f = {WIDTH{^din}};
            ModeInv:  din_f = ~din;
            default:  din_f = din;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din_f;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_comb begin
        delay_d    = delay_q;
        mode_d     = mode_q;
        fill_cnt_d = fill_cnt_q;
        if (en && (fill_cnt_q < FillMax)) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end
        // A new tap invalidates the output until it has been refilled.
        if (cfg_load) begin
            delay_d    = (cfg_delay > MaxDelay) ? MaxDelay : cfg_delay;
            mode_d     = cfg_mode;
            fill_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= {WIDTH{RESET_VAL}};
            end
            delay_q    <= MaxDelay;
            mode_q     <= ModeAnd;
            fill_cnt_q <= '0;
        end else begin
            stage_q    <= stage_d;
            delay_q    <= delay_d;
            mode_q     <= mode_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign dout       = stage_q[delay_q];
    assign dout_valid = (fill_cnt_q > {1'b0, delay_q});

endmodule

// File: tb/tb_delay_line_prog.sv
module tb_delay_line_prog;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 100;
    localparam int unsigned DW        = $clog2(DEPTH);
    localparam bit          RESET_VAL = 1'b1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_load;
    logic [DW-1:0]    cfg_delay;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    always #5 clk = ~clk;

    delay_line_prog #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_delay  (cfg_delay),
        .cfg_mode   (cfg_mode),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic             valid;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: history of transformed samples, newest first.
    logic [WIDTH-1:0] hist[$];
    int               m_delay;
    int               m_mode;
    int               m_fill;

    function automatic logic [WIDTH-1:0] ref_f(input int mode, input logic [WIDTH-1:0] d);
        case (mode)
            0:       return d;
            1:       return (d == {WIDTH{1'b1}}) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            2:       return ($countones(d) % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            default: return ~d;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(DEPTH); i++) hist.push_back({WIDTH{RESET_VAL}});
        m_delay = DEPTH - 1;
        m_mode  = 1;
        m_fill  = 0;
    endtask

    // Drive one cycle, update the model at the edge and queue the expected output.
    task automatic step(input logic r, input logic e, input logic l, input int dly,
                        input int md, input logic [WIDTH-1:0] d);
        rst_n     = r;
        en        = e;
        cfg_load  = l;
        cfg_delay = DW'(dly);
        cfg_mode  = 2'(md);
        din       = d;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (e) begin
                hist.push_front(ref_f(m_mode, d));
                void'(hist.pop_back());
                if (m_fill < int'(DEPTH)) m_fill++;
            end
            if (l) begin
                m_delay = (dly > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : dly;
                m_mode  = md;
                m_fill  = 0;
            end
        end
        exp_q.push_back('{dout: hist[m_delay], valid: (m_fill > m_delay)});
        #1;
    endtask

    // Monitor: every cycle the DUT presents an output, compare with the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (dout !== mon_e.dout) begin
                errors++;
                $display("FAIL dout at %0t: got %h expected %h", $time, dout, mon_e.dout);
            end
            checks++;
            if (dout_valid !== mon_e.valid) begin
                errors++;
                $display("FAIL dout_valid at %0t: got %b expected %b", $time, dout_valid,
                         mon_e.valid);
            end
        end
    end

    initial begin
        int dly;
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_delay = '0; cfg_mode = '0; din = '0;

        // Reset
        step(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 0, 0, 8'h3C);

        // T1 legacy: AND-reduce, delay DEPTH-1
        step(1'b1, 1'b1, 1'b0, 0, 0, 8'hFF);
        repeat (105) step(1'b1, 1'b1, 1'b0, 0, 0, 8'h00);
        repeat (10) step(1'b1, 1'b1, 1'b0, 0, 0, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 0, 0, 8'h00);
        repeat (102) step(1'b1, 1'b1, 1'b0, 0, 0, 8'hFF);

        // T2 pass mode, delay 3 (load edge still uses old AND mode)
        step(1'b1, 1'b1, 1'b1, 3, 0, 8'h55);
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(i));

        // T3 stall
        step(1'b1, 1'b0, 1'b1, 2, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(8'h10 + 5 * k));
            step(1'b1, 1'b0, 1'b0, 0, 0, WIDTH'(8'hE0 + k));
            step(1'b1, 1'b0, 1'b0, 0, 0, WIDTH'(8'hD0 + k));
            step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(8'h13 + 5 * k));
            step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(8'h14 + 5 * k));
        end

        // T4 XOR then invert
        step(1'b1, 1'b1, 1'b1, 4, 2, 8'h07);
        repeat (8) step(1'b1, 1'b1, 1'b0, 0, 0, 8'h07);
        step(1'b1, 1'b1, 1'b1, 4, 3, 8'hA5);
        repeat (8) step(1'b1, 1'b1, 1'b0, 0, 0, 8'hA5);

        // T5 reconfigure mid-stream
        step(1'b1, 1'b1, 1'b1, 5, 0, 8'h40);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(8'h41 + i));
        step(1'b1, 1'b1, 1'b1, 1, 0, 8'h60);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(8'h61 + i));

        // T6 reset with cfg_load, then delay boundaries and frozen load
        step(1'b0, 1'b1, 1'b1, 0, 0, 8'h00);
        repeat (3) step(1'b1, 1'b1, 1'b0, 0, 0, 8'h0F);
        step(1'b1, 1'b1, 1'b1, 0, 0, 8'h11);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'($urandom));
        step(1'b1, 1'b1, 1'b1, 127, 0, 8'h22);
        for (int i = 0; i < 110; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(i * 3));
        step(1'b1, 1'b0, 1'b1, 10, 3, 8'h33);
        repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0, 8'h44);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 0, 0, WIDTH'(i + 8'h80));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            dly = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 127);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), dly, $urandom_range(0, 3), WIDTH'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
